// File: rtl/vc_test_check_sink.sv
// Test sink: checks each accepted message against bench-loaded memory m[], with LFSR-driven random backpressure.
// Optional VC_TEST_CHECK_SINK_STOP_ON_ERR_EN: the first mismatch ends reception (enters DONE).
module vc_test_check_sink #(
  parameter int          p_msg_sz    = 8,
  parameter int          p_mem_sz    = 32,
  parameter int          p_max_delay = 0,
  parameter logic [15:0] p_seed      = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      val,
  output logic                      rdy,
  input  logic [p_msg_sz-1:0]       msg,
  input  logic [$clog2(p_mem_sz):0] num_msgs,
  output logic                      done,
  output logic [15:0]               num_recv,
  output logic [15:0]               num_errors
);
  localparam int AW = $clog2(p_mem_sz);
  localparam int NW = AW + 1;
  localparam int DW = $clog2(p_max_delay + 1) + 1;

  typedef enum logic [1:0] {RECV, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [NW-1:0]       idx_q, idx_d;
  logic [DW-1:0]       cnt_q, cnt_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [15:0]         num_recv_q, num_recv_d;
  logic [15:0]         num_errors_q, num_errors_d;
  logic                rdy_q, rdy_d;
  logic                done_q, done_d;
  logic [p_msg_sz-1:0] m [0:p_mem_sz-1];

  logic                xfer;
  logic                mismatch;
  logic                last;
  logic                stop_err;
  logic [DW-1:0]       dly_load;

  // rdy_q is the registered copy of (state == RECV), so val/msg never reach rdy combinationally
  assign xfer     = val && rdy_q && (state_q == RECV);
  assign mismatch = xfer && (msg != m[idx_q[AW-1:0]]);
  assign last     = ((idx_q + NW'(1)) == num_msgs);
  assign dly_load = DW'(32'(lfsr_q) % (p_max_delay + 1));
  assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

`ifdef VC_TEST_CHECK_SINK_STOP_ON_ERR_EN
  assign stop_err = mismatch;
`else
  assign stop_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RECV;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RECV: begin
        if (num_msgs == '0) begin
          state_d = DONE;
        end else if (xfer) begin
          if (last || stop_err) begin
            state_d = DONE;
          end else begin
            cnt_d   = dly_load;
            state_d = (dly_load != '0) ? WAIT : RECV;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - DW'(1);
        if (cnt_q == DW'(1)) state_d = RECV;
      end
      DONE:    state_d = DONE;
      default: state_d = RECV;
    endcase
  end

  always_comb begin
    rdy_d  = (state_d == RECV);
    done_d = (state_d == DONE);
  end

  always_comb begin
    idx_d        = idx_q;
    num_recv_d   = num_recv_q;
    num_errors_d = num_errors_q;
    if (xfer) begin
      idx_d      = idx_q + NW'(1);
      num_recv_d = num_recv_q + 16'd1;
      if (mismatch && (num_errors_q != 16'hFFFF)) num_errors_d = num_errors_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q        <= '0;
      cnt_q        <= '0;
      lfsr_q       <= p_seed;
      num_recv_q   <= '0;
      num_errors_q <= '0;
      rdy_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      num_recv_q   <= num_recv_d;
      num_errors_q <= num_errors_d;
      rdy_q        <= rdy_d;
      done_q       <= done_d;
    end
  end

  assign rdy        = rdy_q;
  assign done       = done_q;
  assign num_recv   = num_recv_q;
  assign num_errors = num_errors_q;

endmodule

// File: tb/tb_vc_test_check_sink.sv
// Directed bench for vc_test_check_sink: one full-throughput instance and one with random backpressure.
module tb_vc_test_check_sink;
  logic        clk = 1'b0;
  logic        reset;
  logic        val, val2;
  logic [7:0]  msg, msg2;
  logic [5:0]  num_msgs;
  logic        rdy, done, rdy2, done2;
  logic [15:0] num_recv, num_errors, num_recv2, num_errors2;
  logic [7:0]  exp_d [0:5];
  int          n_checks = 0;
  int          n_pass   = 0;

`ifdef VC_TEST_CHECK_SINK_STOP_ON_ERR_EN
  localparam int EXP_ERR_RECV = 4;
`else
  localparam int EXP_ERR_RECV = 6;
`endif

  always #5 clk = ~clk;

  vc_test_check_sink #(.p_msg_sz(8), .p_mem_sz(32), .p_max_delay(0), .p_seed(16'hACE1)) dut (
    .clk(clk), .reset(reset), .val(val), .rdy(rdy), .msg(msg), .num_msgs(num_msgs),
    .done(done), .num_recv(num_recv), .num_errors(num_errors));

  vc_test_check_sink #(.p_msg_sz(8), .p_mem_sz(32), .p_max_delay(2), .p_seed(16'hACE1)) dut2 (
    .clk(clk), .reset(reset), .val(val2), .rdy(rdy2), .msg(msg2), .num_msgs(num_msgs),
    .done(done2), .num_recv(num_recv2), .num_errors(num_errors2));

  // Reset is released on a falling edge, so the next rising edge is the first one out of reset.
  task automatic apply_reset;
    reset = 1'b0;
    val   = 1'b0;
    val2  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; val = 1'b0; val2 = 1'b0; msg = '0; msg2 = '0; num_msgs = 6'd6;
    @(negedge clk);
    n_checks++; if (rdy !== 1'b0) $display("FAIL rst_rdy: got %b expected 0", rdy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (num_recv !== 16'd0) $display("FAIL rst_recv: got %0d expected 0", num_recv); else n_pass++;
    n_checks++; if (num_errors !== 16'd0) $display("FAIL rst_errors: got %0d expected 0", num_errors); else n_pass++;
    n_checks++; if (rdy2 !== 1'b0) $display("FAIL rst_rdy2: got %b expected 0", rdy2); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (rdy !== 1'b1) $display("FAIL rst_release_rdy: got %b expected 1", rdy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_release_done: got %b expected 0", done); else n_pass++;
  endtask

  task automatic test_back_to_back;
    num_msgs = 6'd6;
    apply_reset();
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (rdy !== 1'b1) $display("FAIL b2b_rdy[%0d]: got %b expected 1", k, rdy); else n_pass++;
      val = 1'b1; msg = exp_d[k];
      @(negedge clk);
      n_checks++; if (num_recv !== 16'(k + 1)) $display("FAIL b2b_recv[%0d]: got %0d expected %0d", k, num_recv, k + 1); else n_pass++;
    end
    val = 1'b0;
    n_checks++; if (done !== 1'b1) $display("FAIL b2b_done: got %b expected 1", done); else n_pass++;
    n_checks++; if (rdy !== 1'b0) $display("FAIL b2b_rdy_end: got %b expected 0", rdy); else n_pass++;
    n_checks++; if (num_errors !== 16'd0) $display("FAIL b2b_errors: got %0d expected 0", num_errors); else n_pass++;
    // val held high in DONE must not be counted
    val = 1'b1; msg = 8'h11;
    repeat (3) @(negedge clk);
    val = 1'b0;
    n_checks++; if (num_recv !== 16'd6) $display("FAIL b2b_done_ignore: got %0d expected 6", num_recv); else n_pass++;
  endtask

  task automatic test_backpressure;
    int  k, gap, cyc;
    bit  pend, saw_gap;
    num_msgs = 6'd6;
    apply_reset();
    k = 0; gap = 0; cyc = 0; pend = 1'b0; saw_gap = 1'b0;
    msg2 = exp_d[0]; val2 = 1'b1;
    while (k < 6 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (pend) begin msg2 = exp_d[k]; pend = 1'b0; end
      if (rdy2 === 1'b1) begin
        if (k > 0) begin
          n_checks++; if (gap > 2) $display("FAIL bp_gap[%0d]: got %0d expected <=2", k, gap); else n_pass++;
          if (gap > 0) saw_gap = 1'b1;
        end
        gap = 0; k++; pend = 1'b1;
      end else if (k > 0) begin
        gap++;
      end
    end
    @(negedge clk);
    val2 = 1'b0;
    n_checks++; if (k != 6) $display("FAIL bp_accepts: got %0d expected 6 within 30 cycles", k); else n_pass++;
    n_checks++; if (!saw_gap) $display("FAIL bp_gap_seen: got no rdy-low gap expected at least one"); else n_pass++;
    n_checks++; if (done2 !== 1'b1) $display("FAIL bp_done: got %b expected 1", done2); else n_pass++;
    n_checks++; if (num_errors2 !== 16'd0) $display("FAIL bp_errors: got %0d expected 0", num_errors2); else n_pass++;
    n_checks++; if (num_recv2 !== 16'd6) $display("FAIL bp_recv: got %0d expected 6", num_recv2); else n_pass++;
  endtask

  task automatic test_mismatch;
    num_msgs = 6'd6;
    apply_reset();
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      val = 1'b1; msg = (k == 3) ? 8'h00 : exp_d[k];
      @(negedge clk);
      if (k == 2) begin
        n_checks++; if (num_errors !== 16'd0) $display("FAIL err_before: got %0d expected 0", num_errors); else n_pass++;
      end
      if (k == 3) begin
        n_checks++; if (num_errors !== 16'd1) $display("FAIL err_at4: got %0d expected 1", num_errors); else n_pass++;
      end
    end
    val = 1'b0;
    @(negedge clk);
    n_checks++; if (num_errors !== 16'd1) $display("FAIL err_count: got %0d expected 1", num_errors); else n_pass++;
    n_checks++; if (num_recv !== 16'(EXP_ERR_RECV)) $display("FAIL err_recv: got %0d expected %0d", num_recv, EXP_ERR_RECV); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL err_done: got %b expected 1", done); else n_pass++;
    n_checks++; if (rdy !== 1'b0) $display("FAIL err_rdy: got %b expected 0", rdy); else n_pass++;
  endtask

  task automatic test_reset_mid;
    num_msgs = 6'd6;
    apply_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      val = 1'b1; msg = exp_d[k];
      @(negedge clk);
    end
    val = 1'b1; msg = exp_d[3];
    #2 reset = 1'b0;
    #1;
    n_checks++; if (num_recv !== 16'd0) $display("FAIL mid_recv: got %0d expected 0", num_recv); else n_pass++;
    n_checks++; if (num_errors !== 16'd0) $display("FAIL mid_errors: got %0d expected 0", num_errors); else n_pass++;
    n_checks++; if (rdy !== 1'b0) $display("FAIL mid_rdy: got %b expected 0", rdy); else n_pass++;
    @(negedge clk);
    n_checks++; if (num_recv !== 16'd0) $display("FAIL mid_hold_recv: got %0d expected 0", num_recv); else n_pass++;
    val = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      val = 1'b1; msg = exp_d[k];
      @(negedge clk);
    end
    val = 1'b0;
    n_checks++; if (num_recv !== 16'd6) $display("FAIL mid_rerun_recv: got %0d expected 6", num_recv); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL mid_rerun_done: got %b expected 1", done); else n_pass++;
    n_checks++; if (num_errors !== 16'd0) $display("FAIL mid_rerun_errors: got %0d expected 0", num_errors); else n_pass++;
  endtask

  task automatic test_zero_msgs;
    bit saw_rdy;
    num_msgs = 6'd0;
    apply_reset();
    val = 1'b1; msg = exp_d[0];
    saw_rdy = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done: got %b expected 1", done); else n_pass++;
    if (rdy !== 1'b0) saw_rdy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rdy !== 1'b0) saw_rdy = 1'b1;
    end
    val = 1'b0;
    n_checks++; if (saw_rdy) $display("FAIL zero_rdy: got rdy asserted expected never"); else n_pass++;
    n_checks++; if (num_recv !== 16'd0) $display("FAIL zero_recv: got %0d expected 0", num_recv); else n_pass++;
  endtask

  initial begin
    exp_d[0] = 8'haa; exp_d[1] = 8'hbb; exp_d[2] = 8'hcc;
    exp_d[3] = 8'hdd; exp_d[4] = 8'hee; exp_d[5] = 8'hff;
    for (int i = 0; i < 32; i++) begin
      dut.m[i]  = (i < 6) ? exp_d[i] : 8'h00;
      dut2.m[i] = (i < 6) ? exp_d[i] : 8'h00;
    end
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_mismatch();
    test_reset_mid();
    test_zero_msgs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
